// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine sequencer.
//   wash_state_t   : state encoding, also exported on state_o for debug
//   wash_out_t     : one bit per driver output, decoded from the state
//   state_outputs  : Moore output set for each state
//   is_timed / is_fill_drain / is_abortable : state classification helpers
package wash_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        FILL_WASH   = 4'd1,
        WAIT_DET    = 4'd2,
        WASH        = 4'd3,
        DRAIN_WASH  = 4'd4,
        FILL_RINSE  = 4'd5,
        RINSE       = 4'd6,
        DRAIN_RINSE = 4'd7,
        SPIN        = 4'd8,
        DONE        = 4'd9,
        ABORT_DRAIN = 4'd10,
        FAULT       = 4'd11
    } wash_state_t;

    typedef struct packed {
        logic lock;
        logic motor;
        logic fill;
        logic drain;
        logic water_wash;
        logic done;
        logic fault;
    } wash_out_t;

    //                                       lock motor fill drain water done fault
    localparam wash_out_t OUT_NONE        = 7'b0_0_0_0_0_0_0;
    localparam wash_out_t OUT_FILL_WASH   = 7'b1_0_1_0_0_0_0;
    localparam wash_out_t OUT_WAIT_DET    = 7'b1_0_0_0_0_0_0;
    localparam wash_out_t OUT_WASH        = 7'b1_1_0_0_0_0_0;
    localparam wash_out_t OUT_DRAIN       = 7'b1_0_0_1_0_0_0;
    localparam wash_out_t OUT_FILL_RINSE  = 7'b1_0_1_0_1_0_0;
    localparam wash_out_t OUT_RINSE       = 7'b1_1_0_0_1_0_0;
    localparam wash_out_t OUT_SPIN        = 7'b1_1_0_1_0_0_0;
    localparam wash_out_t OUT_DONE        = 7'b0_0_0_0_0_1_0;
    localparam wash_out_t OUT_FAULT       = 7'b1_0_0_0_0_0_1;

    function automatic wash_out_t state_outputs(input wash_state_t s);
        case (s)
            FILL_WASH:   return OUT_FILL_WASH;
            WAIT_DET:    return OUT_WAIT_DET;
            WASH:        return OUT_WASH;
            DRAIN_WASH:  return OUT_DRAIN;
            FILL_RINSE:  return OUT_FILL_RINSE;
            RINSE:       return OUT_RINSE;
            DRAIN_RINSE: return OUT_DRAIN;
            SPIN:        return OUT_SPIN;
            DONE:        return OUT_DONE;
            ABORT_DRAIN: return OUT_DRAIN;
            FAULT:       return OUT_FAULT;
            default:     return OUT_NONE;
        endcase
    endfunction

    function automatic logic is_timed(input wash_state_t s);
        return (s == WASH) || (s == RINSE) || (s == SPIN);
    endfunction

    function automatic logic is_fill_drain(input wash_state_t s);
        return (s == FILL_WASH) || (s == DRAIN_WASH) || (s == FILL_RINSE) ||
               (s == DRAIN_RINSE) || (s == ABORT_DRAIN);
    endfunction

    // Every state between the first fill and the end of spin has water or a
    // moving drum behind the door, so opening it must force a drain.
    function automatic logic is_abortable(input wash_state_t s);
        return (s >= FILL_WASH) && (s <= SPIN);
    endfunction

endpackage

// File: rtl/wash_tick_timer.sv
// Loadable tick-qualified down-counter.
//   clk, reset : clock, async active-high reset (count cleared)
//   load       : load load_val this clock (wins over tick)
//   load_val   : start value, i.e. phase length in ticks minus one
//   tick       : timebase enable; count moves only when 1
//   expired    : count is zero and a tick arrives, so a load of N-1
//                expires on exactly the N-th tick after loading
module wash_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = tick && (count_q == '0) && !load;

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer: wash -> RINSES rinses -> spin, with door-open
// abort through a safe drain and an extra-rinse request from DONE.
// Optional feature macro: WM_FILL_WATCHDOG_EN adds a fill/drain watchdog
// that sends the machine to FAULT (left only by reset).
// Ports:
//   clk, reset        clock, async active-high reset
//   tick              timebase enable for all timers
//   start             run request (level)
//   door_close        1 = door closed
//   filled, drained   drum level sensors
//   detergent_added   detergent confirmation
//   againwash         extra rinse request while DONE
//   door_lock, motor_on, fill_val_on, drain_val_on, water_wash, done, fault
//                     Moore outputs decoded from the state register
//   rinse_left        rinse phases still to run
//   state_o           current state encoding
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int WASH_TICKS  = 20,
    parameter int RINSE_TICKS = 10,
    parameter int SPIN_TICKS  = 15,
    parameter int RINSES      = 2,
    parameter int CNT_W       = 8
`ifdef WM_FILL_WATCHDOG_EN
    ,
    parameter int WDOG_TICKS  = 50
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       door_close,
    input  logic       filled,
    input  logic       detergent_added,
    input  logic       drained,
    input  logic       againwash,
    output logic       door_lock,
    output logic       motor_on,
    output logic       fill_val_on,
    output logic       drain_val_on,
    output logic       water_wash,
    output logic       done,
    output logic       fault,
    output logic [3:0] rinse_left,
    output logic [3:0] state_o
);

    localparam logic [CNT_W-1:0] WASH_LD  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] RINSE_LD = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LD  = CNT_W'(SPIN_TICKS - 1);

    wash_state_t      state_q, state_d;
    logic [3:0]       rinse_left_q, rinse_left_d;
    logic             phase_load, phase_exp;
    logic [CNT_W-1:0] phase_val;
    wash_out_t        out;

`ifdef WM_FILL_WATCHDOG_EN
    logic wdog_load, wdog_exp;
`endif

    always_comb begin
        state_d      = state_q;
        rinse_left_d = rinse_left_q;
        case (state_q)
            IDLE:        if (start && door_close) state_d = FILL_WASH;
            FILL_WASH:   if (filled) state_d = WAIT_DET;
            WAIT_DET:    if (detergent_added) state_d = WASH;
            WASH:        if (phase_exp) state_d = DRAIN_WASH;
            DRAIN_WASH: begin
                if (drained) begin
                    if (RINSES == 0) begin
                        state_d = SPIN;
                    end else begin
                        state_d      = FILL_RINSE;
                        rinse_left_d = 4'(RINSES);
                    end
                end
            end
            FILL_RINSE:  if (filled) state_d = RINSE;
            RINSE:       if (phase_exp) state_d = DRAIN_RINSE;
            DRAIN_RINSE: begin
                if (drained) begin
                    rinse_left_d = (rinse_left_q == 4'd0) ? 4'd0 : rinse_left_q - 4'd1;
                    state_d      = (rinse_left_q <= 4'd1) ? SPIN : FILL_RINSE;
                end
            end
            SPIN:        if (phase_exp) state_d = DONE;
            DONE: begin
                if (againwash) begin
                    state_d      = FILL_RINSE;
                    rinse_left_d = 4'd1;
                end else if (!start) begin
                    state_d = IDLE;
                end
            end
            ABORT_DRAIN: if (drained) state_d = IDLE;
            FAULT:       state_d = FAULT;
            default:     state_d = IDLE;
        endcase

`ifdef WM_FILL_WATCHDOG_EN
        // Lowest priority: only fires when the sensor did not move us on.
        if (is_fill_drain(state_q) && (state_d == state_q) && wdog_exp) begin
            state_d = FAULT;
        end
`endif

        // Door abort overrides everything, including a pending rinse count update.
        if (!door_close && is_abortable(state_q)) begin
            state_d      = ABORT_DRAIN;
            rinse_left_d = rinse_left_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rinse_left_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            rinse_left_q <= rinse_left_d;
        end
    end

    // Timers are (re)loaded on the clock that enters the state, so that
    // clock's tick is not counted against the new phase.
    always_comb begin
        phase_load = (state_d != state_q) && is_timed(state_d);
        case (state_d)
            RINSE:   phase_val = RINSE_LD;
            SPIN:    phase_val = SPIN_LD;
            default: phase_val = WASH_LD;
        endcase
    end

    wash_tick_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_load),
        .load_val (phase_val),
        .tick     (tick),
        .expired  (phase_exp)
    );

`ifdef WM_FILL_WATCHDOG_EN
    assign wdog_load = (state_d != state_q) && is_fill_drain(state_d);

    wash_tick_timer #(.CNT_W(CNT_W)) u_wdog_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (wdog_load),
        .load_val (CNT_W'(WDOG_TICKS - 1)),
        .tick     (tick),
        .expired  (wdog_exp)
    );
`endif

    // FAULT is unreachable without the watchdog, so fault decodes to 0 there.
    assign out          = state_outputs(state_q);
    assign door_lock    = out.lock;
    assign motor_on     = out.motor;
    assign fill_val_on  = out.fill;
    assign drain_val_on = out.drain;
    assign water_wash   = out.water_wash;
    assign done         = out.done;
    assign fault        = out.fault;
    assign rinse_left   = rinse_left_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
module tb_wash_cycle_ctrl;

    localparam logic [3:0] S_IDLE = 4'd0, S_FILL_WASH = 4'd1, S_WAIT_DET = 4'd2, S_WASH = 4'd3,
                           S_DRAIN_WASH = 4'd4, S_FILL_RINSE = 4'd5, S_RINSE = 4'd6,
                           S_DRAIN_RINSE = 4'd7, S_SPIN = 4'd8, S_DONE = 4'd9,
                           S_ABORT = 4'd10, S_FAULT = 4'd11;

    // {lock, motor, fill, drain, water_wash, done, fault}
    localparam logic [6:0] O_IDLE = 7'b0000000, O_FILL_WASH = 7'b1010000, O_WAIT_DET = 7'b1000000,
                           O_WASH = 7'b1100000, O_DRAIN = 7'b1001000, O_FILL_RINSE = 7'b1010100,
                           O_RINSE = 7'b1100100, O_SPIN = 7'b1101000, O_DONE = 7'b0000010,
                           O_FAULT = 7'b1000001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick = 1'b1;
    logic start = 1'b0, door_close = 1'b0, filled = 1'b0, detergent_added = 1'b0;
    logic drained = 1'b0, againwash = 1'b0;
    int   tick_every = 1;
    int   tick_div = 0;

    logic door_lock, motor_on, fill_val_on, drain_val_on, water_wash, done, fault;
    logic [3:0] rinse_left, state_o;
    logic door_lock0, motor_on0, fill_val_on0, drain_val_on0, water_wash0, done0, fault0;
    logic [3:0] rinse_left0, state_o0;
    logic [6:0] obs;

    int total = 0;
    int bad = 0;

    assign obs = {door_lock, motor_on, fill_val_on, drain_val_on, water_wash, done, fault};

    always #5 clk = ~clk;

    wash_cycle_ctrl #(
        .WASH_TICKS(4), .RINSE_TICKS(3), .SPIN_TICKS(2), .RINSES(2), .CNT_W(8)
`ifdef WM_FILL_WATCHDOG_EN
        , .WDOG_TICKS(5)
`endif
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .door_close(door_close),
        .filled(filled), .detergent_added(detergent_added), .drained(drained),
        .againwash(againwash), .door_lock(door_lock), .motor_on(motor_on),
        .fill_val_on(fill_val_on), .drain_val_on(drain_val_on), .water_wash(water_wash),
        .done(done), .fault(fault), .rinse_left(rinse_left), .state_o(state_o)
    );

    wash_cycle_ctrl #(
        .WASH_TICKS(4), .RINSE_TICKS(3), .SPIN_TICKS(2), .RINSES(0), .CNT_W(8)
`ifdef WM_FILL_WATCHDOG_EN
        , .WDOG_TICKS(5)
`endif
    ) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .door_close(door_close),
        .filled(filled), .detergent_added(detergent_added), .drained(drained),
        .againwash(againwash), .door_lock(door_lock0), .motor_on(motor_on0),
        .fill_val_on(fill_val_on0), .drain_val_on(drain_val_on0), .water_wash(water_wash0),
        .done(done0), .fault(fault0), .rinse_left(rinse_left0), .state_o(state_o0)
    );

    // Timebase: tick high on one clock out of every tick_every.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_div = tick_div + 1;
            tick = (tick_every <= 1) ? 1'b1 : ((tick_div % tick_every) == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exit(input logic [3:0] s, output int n);
        n = 0;
        while (state_o == s && n < 300) begin
            n++;
            step();
        end
    endtask

    task automatic do_reset();
        start = 0; door_close = 0; filled = 0; detergent_added = 0; drained = 0; againwash = 0;
        tick_every = 1;
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic goto_wash();
        door_close = 1; start = 1;
        step();
        filled = 1;
        step();
        filled = 0; detergent_added = 1;
        step();
        detergent_added = 0;
    endtask

    task automatic pulse_drained();
        drained = 1; step(); drained = 0;
    endtask

    task automatic pulse_filled();
        filled = 1; step(); filled = 0;
    endtask

    task automatic run_to_done();
        int n;
        goto_wash();
        wait_exit(S_WASH, n);
        pulse_drained();
        for (int r = 0; r < 2; r++) begin
            pulse_filled();
            wait_exit(S_RINSE, n);
            pulse_drained();
        end
        wait_exit(S_SPIN, n);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3;
        reset = 1;
        #1;
        total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_o, S_IDLE); end
        total++; if (obs !== O_IDLE) begin bad++; $display("FAIL reset_outputs got=%b want=%b", obs, O_IDLE); end
        total++; if (rinse_left !== 4'd0) begin bad++; $display("FAIL reset_rinse_left got=%0d want=0", rinse_left); end
        do_reset();
        step();
        total++; if (state_o !== S_IDLE) begin bad++; $display("FAIL idle_without_start got=%0d want=%0d", state_o, S_IDLE); end
    endtask

    task automatic test_full_cycle();
        int n;
        do_reset();
        door_close = 1; start = 1;
        step();
        total++; if (state_o !== S_FILL_WASH || obs !== O_FILL_WASH) begin bad++; $display("FAIL fill_wash got=%0d/%b want=%0d/%b", state_o, obs, S_FILL_WASH, O_FILL_WASH); end
        pulse_filled();
        total++; if (state_o !== S_WAIT_DET || obs !== O_WAIT_DET) begin bad++; $display("FAIL wait_det got=%0d/%b want=%0d/%b", state_o, obs, S_WAIT_DET, O_WAIT_DET); end
        detergent_added = 1; step(); detergent_added = 0;
        total++; if (state_o !== S_WASH || obs !== O_WASH) begin bad++; $display("FAIL wash got=%0d/%b want=%0d/%b", state_o, obs, S_WASH, O_WASH); end
        wait_exit(S_WASH, n);
        total++; if (n !== 4) begin bad++; $display("FAIL wash_length got=%0d want=4", n); end
        total++; if (state_o !== S_DRAIN_WASH || obs !== O_DRAIN) begin bad++; $display("FAIL drain_wash got=%0d/%b want=%0d/%b", state_o, obs, S_DRAIN_WASH, O_DRAIN); end
        pulse_drained();
        for (int r = 0; r < 2; r++) begin
            total++; if (state_o !== S_FILL_RINSE || obs !== O_FILL_RINSE) begin bad++; $display("FAIL fill_rinse%0d got=%0d/%b want=%0d/%b", r, state_o, obs, S_FILL_RINSE, O_FILL_RINSE); end
            total++; if (rinse_left !== 4'(2 - r)) begin bad++; $display("FAIL rinse_left%0d got=%0d want=%0d", r, rinse_left, 2 - r); end
            pulse_filled();
            total++; if (state_o !== S_RINSE || obs !== O_RINSE) begin bad++; $display("FAIL rinse%0d got=%0d/%b want=%0d/%b", r, state_o, obs, S_RINSE, O_RINSE); end
            wait_exit(S_RINSE, n);
            total++; if (n !== 3) begin bad++; $display("FAIL rinse_length%0d got=%0d want=3", r, n); end
            total++; if (state_o !== S_DRAIN_RINSE || obs !== O_DRAIN) begin bad++; $display("FAIL drain_rinse%0d got=%0d/%b want=%0d/%b", r, state_o, obs, S_DRAIN_RINSE, O_DRAIN); end
            pulse_drained();
        end
        total++; if (state_o !== S_SPIN || obs !== O_SPIN) begin bad++; $display("FAIL spin got=%0d/%b want=%0d/%b", state_o, obs, S_SPIN, O_SPIN); end
        total++; if (rinse_left !== 4'd0) begin bad++; $display("FAIL rinse_left_end got=%0d want=0", rinse_left); end
        wait_exit(S_SPIN, n);
        total++; if (n !== 2) begin bad++; $display("FAIL spin_length got=%0d want=2", n); end
        total++; if (state_o !== S_DONE || obs !== O_DONE) begin bad++; $display("FAIL done got=%0d/%b want=%0d/%b", state_o, obs, S_DONE, O_DONE); end
        step();
        total++; if (state_o !== S_DONE) begin bad++; $display("FAIL done_hold got=%0d want=%0d", state_o, S_DONE); end
    endtask

    task automatic test_back_to_back();
        start = 0;
        step();
        total++; if (state_o !== S_IDLE || obs !== O_IDLE) begin bad++; $display("FAIL done_to_idle got=%0d/%b want=%0d/%b", state_o, obs, S_IDLE, O_IDLE); end
        start = 1;
        step();
        total++; if (state_o !== S_FILL_WASH) begin bad++; $display("FAIL restart got=%0d want=%0d", state_o, S_FILL_WASH); end
    endtask

    task automatic test_againwash();
        int n;
        do_reset();
        run_to_done();
        total++; if (state_o !== S_DONE) begin bad++; $display("FAIL again_reach_done got=%0d want=%0d", state_o, S_DONE); end
        againwash = 1; step(); againwash = 0;
        total++; if (state_o !== S_FILL_RINSE || rinse_left !== 4'd1) begin bad++; $display("FAIL again_fill got=%0d/%0d want=%0d/1", state_o, rinse_left, S_FILL_RINSE); end
        pulse_filled();
        total++; if (state_o !== S_RINSE) begin bad++; $display("FAIL again_rinse got=%0d want=%0d", state_o, S_RINSE); end
        wait_exit(S_RINSE, n);
        total++; if (n !== 3 || state_o !== S_DRAIN_RINSE) begin bad++; $display("FAIL again_rinse_len got=%0d/%0d want=3/%0d", n, state_o, S_DRAIN_RINSE); end
        pulse_drained();
        total++; if (state_o !== S_SPIN || rinse_left !== 4'd0) begin bad++; $display("FAIL again_spin got=%0d/%0d want=%0d/0", state_o, rinse_left, S_SPIN); end
        wait_exit(S_SPIN, n);
        total++; if (state_o !== S_DONE || obs !== O_DONE) begin bad++; $display("FAIL again_done got=%0d/%b want=%0d/%b", state_o, obs, S_DONE, O_DONE); end
    endtask

    task automatic test_no_rinse();
        int  n;
        logic ww_seen;
        do_reset();
        ww_seen = 1'b0;
        goto_wash();
        n = 0;
        while (state_o0 != S_DRAIN_WASH && n < 50) begin ww_seen |= water_wash0; n++; step(); end
        total++; if (state_o0 !== S_DRAIN_WASH) begin bad++; $display("FAIL norinse_drain got=%0d want=%0d", state_o0, S_DRAIN_WASH); end
        pulse_drained();
        total++; if (state_o0 !== S_SPIN) begin bad++; $display("FAIL norinse_spin got=%0d want=%0d", state_o0, S_SPIN); end
        n = 0;
        while (state_o0 != S_DONE && n < 50) begin ww_seen |= water_wash0; n++; step(); end
        total++; if (state_o0 !== S_DONE || done0 !== 1'b1) begin bad++; $display("FAIL norinse_done got=%0d/%b want=%0d/1", state_o0, done0, S_DONE); end
        total++; if (ww_seen !== 1'b0) begin bad++; $display("FAIL norinse_water got=%b want=0", ww_seen); end
    endtask

    task automatic test_slow_tick();
        int n;
        do_reset();
        tick_every = 4;
        goto_wash();
        wait_exit(S_WASH, n);
        total++; if (n < 13 || n > 19) begin bad++; $display("FAIL slow_wash_length got=%0d want=13..19", n); end
        total++; if (state_o !== S_DRAIN_WASH) begin bad++; $display("FAIL slow_drain got=%0d want=%0d", state_o, S_DRAIN_WASH); end
        tick_every = 1;
    endtask

    task automatic test_door_abort();
        int n;
        do_reset();
        goto_wash();
        step();
        total++; if (state_o !== S_WASH) begin bad++; $display("FAIL abort_in_wash got=%0d want=%0d", state_o, S_WASH); end
        door_close = 0;
        step();
        total++; if (state_o !== S_ABORT || obs !== O_DRAIN) begin bad++; $display("FAIL abort_drain got=%0d/%b want=%0d/%b", state_o, obs, S_ABORT, O_DRAIN); end
        start = 0;
        pulse_drained();
        total++; if (state_o !== S_IDLE || done !== 1'b0) begin bad++; $display("FAIL abort_idle got=%0d/%b want=%0d/0", state_o, done, S_IDLE); end
        // reset in the middle of a rinse
        do_reset();
        goto_wash();
        wait_exit(S_WASH, n);
        pulse_drained();
        pulse_filled();
        total++; if (state_o !== S_RINSE) begin bad++; $display("FAIL midrinse_reach got=%0d want=%0d", state_o, S_RINSE); end
        #3;
        reset = 1;
        #1;
        total++; if (obs !== O_IDLE || state_o !== S_IDLE || rinse_left !== 4'd0) begin bad++; $display("FAIL async_reset got=%b/%0d/%0d want=%b/0/0", obs, state_o, rinse_left, O_IDLE); end
        do_reset();
    endtask

    task automatic test_watchdog();
        int n;
        do_reset();
        door_close = 1; start = 1;
        step();
        total++; if (state_o !== S_FILL_WASH) begin bad++; $display("FAIL wdog_fill got=%0d want=%0d", state_o, S_FILL_WASH); end
`ifdef WM_FILL_WATCHDOG_EN
        wait_exit(S_FILL_WASH, n);
        total++; if (n !== 5) begin bad++; $display("FAIL wdog_time got=%0d want=5", n); end
        total++; if (state_o !== S_FAULT || obs !== O_FAULT) begin bad++; $display("FAIL wdog_fault got=%0d/%b want=%0d/%b", state_o, obs, S_FAULT, O_FAULT); end
        start = 0; door_close = 0;
        repeat (6) step();
        total++; if (state_o !== S_FAULT || obs !== O_FAULT) begin bad++; $display("FAIL wdog_hold got=%0d/%b want=%0d/%b", state_o, obs, S_FAULT, O_FAULT); end
        do_reset();
        total++; if (state_o !== S_IDLE || fault !== 1'b0) begin bad++; $display("FAIL wdog_clear got=%0d/%b want=0/0", state_o, fault); end
`else
        n = 0;
        repeat (60) begin step(); n++; end
        total++; if (state_o !== S_FILL_WASH || obs !== O_FILL_WASH) begin bad++; $display("FAIL nowdog_wait got=%0d/%b want=%0d/%b after %0d clk", state_o, obs, S_FILL_WASH, O_FILL_WASH, n); end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_back_to_back();
        test_againwash();
        test_no_rinse();
        test_slow_tick();
        test_door_abort();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
